// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM sequencer block.
//   - W          : datapath width, fixed to match the PWM timer (16 bits)
//   - SEL_*      : encodings of the PWM write-select port
//   - seq_state_t: sequencer FSM states
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int W = 16;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CMP  = 2'd1;
  localparam logic [1:0] SEL_TOP  = 2'd2;
  localparam logic [1:0] SEL_CNT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WTOP,
    S_RCMP,
    S_RTOP,
    S_RCNT,
    S_RAMP
  } seq_state_t;

endpackage

// File: rtl/pwm_step_calc.sv
// ---------------------------------------------------------------------------
// pwm_step_calc
//   Combinational ramp step: moves cur one step toward cmp_t without ever
//   passing it. A step of zero jumps straight to the target.
//   Ports:
//     cur      in  W : compare value currently programmed
//     cmp_t    in  W : target compare value
//     step     in  W : ramp step (0 = jump)
//     next_cmp out W : next compare value to write
// ---------------------------------------------------------------------------
module pwm_step_calc
  import pwm_pkg::*;
(
  input  logic [W-1:0] cur,
  input  logic [W-1:0] cmp_t,
  input  logic [W-1:0] step,
  output logic [W-1:0] next_cmp
);

  logic         up;
  logic [W:0]   diff;

  // NOTE: every variable driven here gets a value on every path, otherwise
  // synthesis infers a latch to hold the old value.
  always_comb begin
    up   = (cmp_t >= cur);
    diff = up ? ({1'b0, cmp_t} - {1'b0, cur})
              : ({1'b0, cur} - {1'b0, cmp_t});
    if (step == '0 || diff <= {1'b0, step}) begin
      next_cmp = cmp_t;
    end else if (up) begin
      // diff > step here, so cur + step stays below cmp_t and cannot wrap.
      next_cmp = cur + step;
    end else begin
      next_cmp = cur - step;
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_sequencer
//   Programs a 16-bit PWM timer through its d/sel write port so that period
//   and duty updates land on a period boundary (or immediately, with a
//   counter restart), optionally ramping compare toward a target by a fixed
//   step, one write per PWM period.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     req_valid/req_ready  : command handshake (ready only in IDLE)
//     req_top, req_cmp     : new period (top+1 cycles) and target compare
//     req_step             : ramp step, 0 = jump to target
//     req_restart          : apply now and zero the counter
//     pwm_cnt/cmp/top      : readback from the PWM instance
//     pwm_d, pwm_sel       : write port into the PWM instance
//     busy                 : high whenever not IDLE
//     done                 : one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module pwm_sequencer
  import pwm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_top,
  input  logic [W-1:0] req_cmp,
  input  logic [W-1:0] req_step,
  input  logic         req_restart,
  input  logic [W-1:0] pwm_cnt,
  input  logic [W-1:0] pwm_cmp,
  input  logic [W-1:0] pwm_top,
  output logic [W-1:0] pwm_d,
  output logic [1:0]   pwm_sel,
  output logic         busy,
  output logic         done
);

  seq_state_t   state;
  logic [W-1:0] top_t;
  logic [W-1:0] cmp_t;
  logic [W-1:0] step;
  logic [W-1:0] cur;
  logic [W-1:0] next_cmp;
  logic         wrap;

  // Last cycle of the current PWM period.
  assign wrap = (pwm_cnt >= pwm_top);

  pwm_step_calc u_step_calc (
    .cur      (cur),
    .cmp_t    (cmp_t),
    .step     (step),
    .next_cmp (next_cmp)
  );

  // NOTE: state elements use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the latched command registers are reset too; they are a handful
  // of flops, not a memory, and a known value keeps readback deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      top_t <= '0;
      cmp_t <= '0;
      step  <= '0;
      cur   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            top_t <= req_top;
            cmp_t <= req_cmp;
            step  <= req_step;
            cur   <= pwm_cmp;
            // A wrap during this acceptance cycle is deliberately ignored:
            // WAIT only looks at wraps from the next cycle on.
            state <= req_restart ? S_RCMP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wrap) begin
            cur   <= next_cmp;
            state <= S_WTOP;
          end
        end
        S_RCMP: begin
          cur   <= next_cmp;
          state <= S_RTOP;
        end
        S_RTOP: state <= S_RCNT;
        S_WTOP, S_RCNT: begin
          if (cur == cmp_t) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            state <= S_RAMP;
          end
        end
        S_RAMP: begin
          if (wrap) begin
            cur <= next_cmp;
            if (next_cmp == cmp_t) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write port is decoded from state (and wrap for the Mealy compare write),
  // so an asynchronous reset of state clears it in the same cycle.
  always_comb begin
    pwm_sel = SEL_NONE;
    pwm_d   = '0;
    unique case (state)
      S_WAIT, S_RAMP: begin
        if (wrap) begin
          pwm_sel = SEL_CMP;
          pwm_d   = next_cmp;
        end
      end
      S_RCMP: begin
        pwm_sel = SEL_CMP;
        pwm_d   = next_cmp;
      end
      S_WTOP, S_RTOP: begin
        pwm_sel = SEL_TOP;
        pwm_d   = top_t;
      end
      S_RCNT: begin
        pwm_sel = SEL_CNT;
        pwm_d   = '0;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = !req_ready;

endmodule

// File: tb/tb_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_sequencer
//   Directed bench for pwm_sequencer driving a small behavioural PWM timer
//   (cnt counts 0..top, out = cnt < cmp, sel/d writes cmp/top/cnt). The PWM
//   model has its own reset so its registers survive a sequencer reset.
// ---------------------------------------------------------------------------
module tb_pwm_sequencer;

  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        model_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_top = '0;
  logic [15:0] req_cmp = '0;
  logic [15:0] req_step = '0;
  logic        req_restart = 1'b0;
  logic [15:0] pwm_cnt;
  logic [15:0] pwm_cmp;
  logic [15:0] pwm_top;
  logic [15:0] pwm_d;
  logic [1:0]  pwm_sel;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_top     (req_top),
    .req_cmp     (req_cmp),
    .req_step    (req_step),
    .req_restart (req_restart),
    .pwm_cnt     (pwm_cnt),
    .pwm_cmp     (pwm_cmp),
    .pwm_top     (pwm_top),
    .pwm_d       (pwm_d),
    .pwm_sel     (pwm_sel),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural PWM timer. A cnt write overrides counting; otherwise the
  // counter runs 0..top using the top value in force before the edge.
  always_ff @(posedge clk or negedge model_rst_n) begin
    if (!model_rst_n) begin
      pwm_cnt <= 16'd0;
      pwm_cmp <= 16'd0;
      pwm_top <= 16'd15;
    end else begin
      if (pwm_sel == 2'd1) pwm_cmp <= pwm_d;
      if (pwm_sel == 2'd2) pwm_top <= pwm_d;
      if (pwm_sel == 2'd3) pwm_cnt <= pwm_d;
      else                 pwm_cnt <= (pwm_cnt >= pwm_top) ? 16'd0 : pwm_cnt + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] top, input logic [15:0] cmp,
                       input logic [15:0] stp, input logic rst);
    req_top     = top;
    req_cmp     = cmp;
    req_step    = stp;
    req_restart = rst;
    req_valid   = 1'b1;
    step_clk();
    req_valid   = 1'b0;
  endtask

  // Waits (bounded) for the next write cycle, then checks sel/d there.
  task automatic wait_write(input string tag, input logic [1:0] es,
                            input logic [15:0] ed, output int idle_cycles);
    idle_cycles = 0;
    while (pwm_sel == 2'd0 && idle_cycles < BUDGET) begin
      step_clk();
      idle_cycles++;
    end
    check({tag, "_sel"}, 32'(pwm_sel), 32'(es));
    check({tag, "_d"},   32'(pwm_d),   32'(ed));
  endtask

  task automatic duty(input string tag, input int exp_high);
    int high = 0;
    for (int i = 0; i < 10; i++) begin
      if (pwm_cnt < pwm_cmp) high++;
      step_clk();
    end
    check(tag, 32'(high), 32'(exp_high));
  endtask

  initial begin
    int n;

    // Reset
    repeat (3) step_clk();
    check("rst_sel",   32'(pwm_sel),   32'd0);
    check("rst_d",     32'(pwm_d),     32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    rst_n = 1'b1;
    model_rst_n = 1'b1;
    step_clk();

    // Restart: top=9 cmp=3 step=0
    issue(16'd9, 16'd3, 16'd0, 1'b1);
    check("rs_sel1",  32'(pwm_sel),   32'd1);
    check("rs_d1",    32'(pwm_d),     32'd3);
    check("rs_busy",  32'(busy),      32'd1);
    check("rs_ready", 32'(req_ready), 32'd0);
    step_clk();
    check("rs_sel2",  32'(pwm_sel),   32'd2);
    check("rs_d2",    32'(pwm_d),     32'd9);
    check("rs_cmp",   32'(pwm_cmp),   32'd3);
    step_clk();
    check("rs_sel3",  32'(pwm_sel),   32'd3);
    check("rs_d3",    32'(pwm_d),     32'd0);
    check("rs_top",   32'(pwm_top),   32'd9);
    step_clk();
    check("rs_cnt",   32'(pwm_cnt),   32'd0);
    check("rs_done",  32'(done),      32'd1);
    check("rs_idle",  32'(busy),      32'd0);
    step_clk();
    check("rs_done_pulse", 32'(done), 32'd0);
    duty("rs_duty", 3);

    // Normal change to 4/2, accepted in a wrap cycle (that wrap is not used)
    n = 0;
    while (pwm_cnt != 16'd9 && n < BUDGET) begin
      step_clk();
      n++;
    end
    issue(16'd4, 16'd2, 16'd0, 1'b0);
    wait_write("nc_cmp", 2'd1, 16'd2, n);
    check("nc_wait_cycles", 32'(n),       32'd9);
    check("nc_wrap_cnt",    32'(pwm_cnt), 32'd9);
    step_clk();
    check("nc_sel_top", 32'(pwm_sel), 32'd2);
    check("nc_d_top",   32'(pwm_d),   32'd4);
    check("nc_cmp",     32'(pwm_cmp), 32'd2);
    step_clk();
    check("nc_done",    32'(done),    32'd1);
    check("nc_top",     32'(pwm_top), 32'd4);
    duty("nc_duty", 4);

    // Ramp up: cmp 2 -> 9, step 3, top back to 9
    issue(16'd9, 16'd9, 16'd3, 1'b0);
    wait_write("ru_w1", 2'd1, 16'd5, n);
    step_clk();
    check("ru_sel_top", 32'(pwm_sel), 32'd2);
    check("ru_d_top",   32'(pwm_d),   32'd9);
    step_clk();
    wait_write("ru_w2", 2'd1, 16'd8, n);
    check("ru_busy2", 32'(busy), 32'd1);
    step_clk();
    wait_write("ru_w3", 2'd1, 16'd9, n);
    check("ru_busy3", 32'(busy), 32'd1);
    step_clk();
    check("ru_done", 32'(done),    32'd1);
    check("ru_cmp",  32'(pwm_cmp), 32'd9);

    // Ramp down: cmp 9 -> 0, step 4, stray request ignored
    issue(16'd9, 16'd0, 16'd4, 1'b0);
    wait_write("rd_w1", 2'd1, 16'd5, n);
    step_clk();
    check("rd_sel_top", 32'(pwm_sel), 32'd2);
    step_clk();
    req_top = 16'd3; req_cmp = 16'd7; req_step = 16'd0; req_restart = 1'b1;
    req_valid = 1'b1;
    check("rd_ready_busy", 32'(req_ready), 32'd0);
    step_clk();
    req_valid = 1'b0;
    wait_write("rd_w2", 2'd1, 16'd1, n);
    step_clk();
    wait_write("rd_w3", 2'd1, 16'd0, n);
    step_clk();
    check("rd_done", 32'(done),    32'd1);
    check("rd_cmp",  32'(pwm_cmp), 32'd0);
    check("rd_top",  32'(pwm_top), 32'd9);

    // Reset mid-ramp: cmp 0 -> 9, step 5, reset after the write of 5
    issue(16'd9, 16'd9, 16'd5, 1'b0);
    wait_write("rm_w1", 2'd1, 16'd5, n);
    step_clk();
    check("rm_cmp_written", 32'(pwm_cmp), 32'd5);
    rst_n = 1'b0;
    #1;
    check("rm_sel",   32'(pwm_sel),   32'd0);
    check("rm_d",     32'(pwm_d),     32'd0);
    check("rm_busy",  32'(busy),      32'd0);
    check("rm_ready", 32'(req_ready), 32'd1);
    repeat (2) step_clk();
    check("rm_cmp_kept", 32'(pwm_cmp), 32'd5);
    rst_n = 1'b1;
    step_clk();
    issue(16'd9, 16'd4, 16'd0, 1'b1);
    check("rm_new_sel", 32'(pwm_sel), 32'd1);
    check("rm_new_d",   32'(pwm_d),   32'd4);
    repeat (3) step_clk();
    check("rm_new_done", 32'(done),    32'd1);
    check("rm_new_cmp",  32'(pwm_cmp), 32'd4);
    check("rm_new_cnt",  32'(pwm_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Programs the 16-bit `PWM` timer through its `d`/`sel` write port so that period and duty changes take effect without mid-period glitches. It optionally ramps the compare value toward a target by a fixed step, one step per PWM period. It sits between a simple valid/ready command source (CPU-side register or test sequencer) and one `PWM` instance, and reads that instance's `cnt`, `cmp` and `top` outputs back.

## Interface
- No parameters; widths are fixed at 16 bits to match `PWM`.
- `clk` in 1: single clock, shared with `PWM`.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: high only in IDLE.
- `req_top` in 16: new period value; period is top+1 cycles.
- `req_cmp` in 16: target compare value.
- `req_step` in 16: ramp step; 0 means jump directly to the target.
- `req_restart` in 1: apply immediately and zero the counter, without waiting for a wrap.
- `pwm_cnt`, `pwm_cmp`, `pwm_top` in 16 each: readback from `PWM`.
- `pwm_d` out 16: drives `PWM.d`.
- `pwm_sel` out 2: drives `PWM.sel`. Values: 0 none, 1 cmp, 2 top, 3 cnt.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- **States:** IDLE, WAIT, WTOP, RCMP, RTOP, RCNT, RAMP.
- **Command acceptance:**
  - A command is accepted on the edge where `req_valid && req_ready`.
  - At acceptance, latch `top_t`, `cmp_t`, `step`, `restart`, and set `cur` = `pwm_cmp`.
  - `req_valid` while busy is ignored; the command is not queued.
- **Wrap condition:** `wrap = (pwm_cnt >= pwm_top)`. This is the last cycle of a PWM period.
- **`next_cmp` computation:**
  - If `step == 0` or |`cmp_t` − `cur`| ≤ `step`: `next_cmp` = `cmp_t`.
  - Otherwise: `next_cmp` = `cur` ± `step`, moving toward `cmp_t`.
  - Unsigned arithmetic with a 17-bit difference; the result never wraps past `cmp_t`.
- **Normal path (`restart` = 0):**
  - In WAIT, drive `sel`=0. On a `wrap` cycle, drive `sel`=1, `d`=`next_cmp` (Mealy), update `cur`, and go to WTOP.
  - In WTOP, drive `sel`=2, `d`=`top_t`.
  - Writing cmp on the wrap edge and top one cycle later means the first cycle of the new period already uses the new cmp.
- **Restart path (`restart` = 1):**
  - RCMP: `sel`=1, `d`=`next_cmp`.
  - RTOP: `sel`=2, `d`=`top_t`.
  - RCNT: `sel`=3, `d`=0.
  - These are three consecutive cycles, starting the cycle after acceptance.
- **Ramp completion:**
  - After WTOP or RCNT: if `cur == cmp_t`, go to IDLE; otherwise go to RAMP.
  - In RAMP, on each `wrap` cycle drive `sel`=1, `d`=`next_cmp`, and update `cur`. Stay in RAMP until `cur == cmp_t`, then go to IDLE.
- **`done`:** registered; high in the first IDLE cycle after a completed command.
- **Outputs outside write cycles:** `pwm_sel`=0 and `pwm_d`=0.

## Timing
- **Reset values:** state=IDLE, `pwm_sel`=0, `pwm_d`=0, `busy`=0, `done`=0, `req_ready`=1.
- **Reset mid-operation:**
  - Asserting `rst_n` forces outputs to reset values immediately (asynchronous).
  - Already-committed `PWM` registers keep their values; a partial sequence is not rolled back.
- **Restart latency:** accept at edge E0. cmp is updated at E1, top at E2, cnt=0 at E3. `done` is high during cycle E3–E4.
- **Normal latency:** the cmp write lands on the first wrap edge Ew after acceptance. top lands at Ew+1, and `done` follows one cycle after the final write.
- **Wrap in the acceptance cycle:** if `wrap` is true in the acceptance cycle itself, it is not used; the sequencer waits for the next wrap.
- **`pwm_top` == 0:** `wrap` is true every cycle, so WAIT exits on its first cycle.
- **Ramp rate:** one compare write per period; never more than one write per cycle.

## Structure
- Package `pwm_pkg`:
  - Constants `SEL_NONE`/`SEL_CMP`/`SEL_TOP`/`SEL_CNT`.
  - State enum `seq_state_t`.
  - `localparam W = 16`.
- Sub-module `pwm_step_calc`: combinational; inputs `cur`, `cmp_t`, `step`; output `next_cmp`. Unit-testable alone.
- A top-level test wrapper instantiates `pwm_sequencer` plus `PWM` with `sel`/`d` connected.

## Test plan
- **Reset:** hold `rst_n`=0 → `sel`=0, `d`=0, `req_ready`=1, `busy`=0, `done`=0.
- **Restart:** `top`=9, `cmp`=3, `step`=0, `restart`=1 → `sel`/`d` = 1/3, 2/9, 3/0 in three consecutive cycles. `done` follows one cycle later; `out` is then high 3 of every 10 cycles.
- **Normal change:** while running 9/3, request `top`=4, `cmp`=2 → no writes until `cnt`=9. Then 1/2 in that cycle and 2/4 the next. Subsequent periods are 5 cycles with `out` high for 2; no 1-cycle glitch.
- **Ramp up:** from `cmp`=2, `top`=9, request `cmp`=9, `step`=3 → `cmp` writes 5, 8, 9 on three successive wraps. `done` follows the write of 9; `busy`=1 throughout.
- **Ramp down, no overshoot:** from `cmp`=9, request `cmp`=0, `step`=4 → writes 5, 1, 0. A `req_valid` pulse during the ramp is ignored.
- **Reset mid-ramp:** drop `rst_n` after the write of 5 → `sel`=0 in the same cycle and `busy`=0. `PWM` `cmp` stays 5, and a new command is accepted after `rst_n` releases.
